// File: rtl/encoder_prio_n_pkg.sv
// Shared constants for the pending-request priority encoder.
// Build option: ENCODER_MASK_EN adds a per-request eligibility mask port.
package encoder_prio_n_pkg;

  localparam int unsigned N_MAX    = 32;
  localparam int unsigned RR_FIXED = 0;
  localparam int unsigned RR_ROUND = 1;

  // Index width for an N-input encoder, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner search over the eligible vector, starting at start.
// Round-robin scans upward modulo N; fixed priority scans downward from start.
module prio_pick
  import encoder_prio_n_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 2,
  parameter int unsigned RR_MODE = RR_FIXED
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx_c,
  output logic         any_c
);

  int unsigned pos;

  // Scan from the farthest candidate back to start so the nearest one wins.
  always_comb begin
    idx_c = '0;
    any_c = |elig;
    pos   = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (RR_MODE == RR_ROUND) begin
        pos = (32'(start) + 32'(k)) % N;
      end else begin
        pos = 32'(start) - 32'(k);
      end
      if (elig[W'(pos)]) begin
        idx_c = W'(pos);
      end
    end
  end

endmodule

// File: rtl/encoder_prio_n.sv
// Pending-request register with fixed or round-robin winner selection and ack-clear.
// Build option: ENCODER_MASK_EN adds input mask; masked requests latch but cannot win.
module encoder_prio_n
  import encoder_prio_n_pkg::*;
#(
  parameter  int unsigned N       = 4,
  parameter  int unsigned RR_MODE = RR_FIXED,
  localparam int unsigned W       = idx_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] x,
  input  logic         ack,
`ifdef ENCODER_MASK_EN
  input  logic [N-1:0] mask,
`endif
  output logic [W-1:0] idx,
  output logic         valid,
  output logic [N-1:0] pending
);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic [W-1:0] start;
  logic [W-1:0] win_idx;
  logic         win_any;

`ifdef ENCODER_MASK_EN
  assign elig = pending_q & ~mask;
`else
  assign elig = pending_q;
`endif

  assign start = (RR_MODE == RR_ROUND) ? rr_ptr_q : W'(N - 1);

  prio_pick #(
    .N       (N),
    .W       (W),
    .RR_MODE (RR_MODE)
  ) u_pick (
    .elig  (elig),
    .start (start),
    .idx_c (win_idx),
    .any_c (win_any)
  );

  // New requests are OR-ed in after the clear, so a same-cycle set survives an ack.
  always_comb begin
    clr       = '0;
    rr_ptr_d  = rr_ptr_q;
    if (ack && win_any) begin
      clr = N'(1) << win_idx;
      if (RR_MODE == RR_ROUND) begin
        rr_ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
      end
    end
    pending_d = (pending_q & ~clr) | x;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign idx     = win_idx;
  assign valid   = win_any;
  assign pending = pending_q;

endmodule

// File: tb/tb_encoder_prio_n.sv
// Bench for encoder_prio_n: a fixed-priority N=4 instance and a round-robin N=5 instance.
module tb_encoder_prio_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] x_f, mask_f, pend_f;
  logic [4:0] x_r, mask_r, pend_r;
  logic       ack_f, ack_r, valid_f, valid_r;
  logic [1:0] idx_f;
  logic [2:0] idx_r;

  // Reference state
  logic [3:0] fp;
  logic [4:0] rp;
  int         rptr;
  int         vectors = 0;
  int         errs    = 0;

  always #5 clk = ~clk;

  encoder_prio_n #(.N(4), .RR_MODE(0)) u_fix (
    .clk     (clk),
    .reset   (reset),
    .x       (x_f),
    .ack     (ack_f),
`ifdef ENCODER_MASK_EN
    .mask    (mask_f),
`endif
    .idx     (idx_f),
    .valid   (valid_f),
    .pending (pend_f)
  );

  encoder_prio_n #(.N(5), .RR_MODE(1)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .x       (x_r),
    .ack     (ack_r),
`ifdef ENCODER_MASK_EN
    .mask    (mask_r),
`endif
    .idx     (idx_r),
    .valid   (valid_r),
    .pending (pend_r)
  );

  // Highest-numbered eligible request wins.
  function automatic void fix_ref(input logic [3:0] e, output int w, output bit v);
    w = 0;
    v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (e[i]) begin
        w = i;
        v = 1'b1;
      end
    end
  endfunction

  // First eligible request at or after ptr, wrapping modulo 5.
  function automatic void rr_ref(input logic [4:0] e, input int ptr, output int w, output bit v);
    w = 0;
    v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!v && e[(ptr + k) % 5]) begin
        w = (ptr + k) % 5;
        v = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock with the current inputs, update the reference, then compare.
  task automatic tick(input string tag);
    int fw, rw;
    bit fv, rv;
`ifdef ENCODER_MASK_EN
    fix_ref(fp & ~mask_f, fw, fv);
    rr_ref(rp & ~mask_r, rptr, rw, rv);
`else
    fix_ref(fp, fw, fv);
    rr_ref(rp, rptr, rw, rv);
`endif
    @(posedge clk);
    if (reset) begin
      fp   = '0;
      rp   = '0;
      rptr = 0;
    end else begin
      if (ack_f && fv) fp[fw] = 1'b0;
      fp = fp | x_f;
      if (ack_r && rv) begin
        rp[rw] = 1'b0;
        rptr   = (rw + 1) % 5;
      end
      rp = rp | x_r;
    end
    #1;
`ifdef ENCODER_MASK_EN
    fix_ref(fp & ~mask_f, fw, fv);
    rr_ref(rp & ~mask_r, rptr, rw, rv);
`else
    fix_ref(fp, fw, fv);
    rr_ref(rp, rptr, rw, rv);
`endif
    chk({tag, "/fix_pending"}, 32'(pend_f), 32'(fp));
    chk({tag, "/fix_valid"},   32'(valid_f), 32'(fv));
    chk({tag, "/fix_idx"},     32'(idx_f), fv ? 32'(fw) : 32'd0);
    chk({tag, "/rr_pending"},  32'(pend_r), 32'(rp));
    chk({tag, "/rr_valid"},    32'(valid_r), 32'(rv));
    chk({tag, "/rr_idx"},      32'(idx_r), rv ? 32'(rw) : 32'd0);
  endtask

  initial begin
    int rr_seq [4] = '{0, 4, 0, 4};
    fp = '0; rp = '0; rptr = 0;
    mask_f = '0; mask_r = '0;
    ack_f = 1'b0; ack_r = 1'b0;
    x_f = 4'b1111; x_r = 5'b11111;
    reset = 1'b1;

    // Reset dominates held requests.
    tick("rst0");
    tick("rst1");
    chk("rst_pending_zero", 32'(pend_f), 32'd0);
    chk("rst_valid_zero", 32'(valid_f), 32'd0);
    reset = 1'b0;
    tick("rel");
    chk("rel_pending", 32'(pend_f), 32'hf);
    chk("rel_idx", 32'(idx_f), 32'd3);

    // Drain everything with acks held.
    x_f = '0; x_r = '0; ack_f = 1'b1; ack_r = 1'b1;
    for (int i = 0; i < 6; i++) tick("drain");
    chk("drained_valid", 32'(valid_f), 32'd0);

    // Fixed drain of 1010: idx 3 then 1 then empty.
    ack_f = 1'b0;
    x_f = 4'b1010;
    tick("pulse");
    x_f = '0; ack_f = 1'b1;
    chk("fd_idx3", 32'(idx_f), 32'd3);
    tick("fd1");
    chk("fd_idx1", 32'(idx_f), 32'd1);
    tick("fd2");
    chk("fd_empty", 32'(valid_f), 32'd0);
    tick("fd3");

    // Set beats clear on the acked bit.
    ack_f = 1'b0; x_f = 4'b0100;
    tick("svc_load");
    ack_f = 1'b1;
    tick("svc_ack");
    chk("svc_pending", 32'(pend_f), 32'h4);
    chk("svc_valid", 32'(valid_f), 32'd1);
    x_f = '0;
    tick("svc_clear");

    // Acks while empty leave state alone.
    for (int i = 0; i < 3; i++) tick("ack_empty");
    chk("ack_empty_pending", 32'(pend_f), 32'd0);

    // Round-robin wrap with requests 4 and 0 held.
    x_r = 5'b10001; ack_r = 1'b1;
    tick("rr_load");
    for (int i = 0; i < 4; i++) begin
      chk("rr_wrap_idx", 32'(idx_r), 32'(rr_seq[i]));
      tick("rr_wrap");
    end

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      x_f   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      x_r   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : '0;
      ack_f = 1'($urandom);
      ack_r = 1'($urandom);
`ifdef ENCODER_MASK_EN
      mask_f = ($urandom_range(0, 4) == 0) ? 4'($urandom) : '0;
      mask_r = ($urandom_range(0, 4) == 0) ? 5'($urandom) : '0;
`endif
      reset = ($urandom_range(0, 99) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
